credit_stage_bank: RTL and testbench
====================================

Name: credit_stage_bank

Overview:
- Parametrised bank of per-output-port timed credit FIFOs for the NoC router.
- Each returned credit is stamped with cycle + credit delay and held until that cycle is reached, then released to the upstream credit path in FIFO order.
- Generalises the fixed per-port credit staging queue in four ways: configurable port count, depth and field widths; exact full detection with no wasted slot; wrap-safe timestamp compare; backpressured release with occupancy and overflow reporting.

Parameters:
- NUM_PORTS, 4, number of independent port queues.
- DEPTH, 8, entries per queue; any value >= 2, not required to be a power of two.
- VC_W, 3, width of the VC id carried per credit.
- TIME_W, 16, width of the internal cycle counter and of the timestamps.
- DEFAULT_DELAY, 4, credit delay loaded at reset; must be < 2^(TIME_W-1).

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous reset, active-high
- cfg_we  in  1  load delay_cfg into the delay register
- delay_cfg  in  TIME_W  new credit delay; must be < 2^(TIME_W-1)
- push_valid  in  NUM_PORTS  credit enqueue request, one bit per port
- push_vc  in  NUM_PORTS*VC_W  VC of each pushed credit; port p occupies bits [p*VC_W +: VC_W]
- pop_valid  out  NUM_PORTS  head entry is present and matured
- pop_vc  out  NUM_PORTS*VC_W  VC of each head entry
- pop_ready  in  NUM_PORTS  consumer accepts the head entry
- full  out  NUM_PORTS  count == DEPTH
- empty  out  NUM_PORTS  count == 0
- count  out  NUM_PORTS*CW  occupancy per port; CW = clog2(DEPTH+1)
- overflow  out  NUM_PORTS  sticky: a push was dropped
- clear_ovf  in  NUM_PORTS  clear the sticky overflow bit
- now  out  TIME_W  free-running cycle counter

Behaviour:
- Reset (async, any time, including mid-operation):
  - all queues empty; count = 0; empty = 1; full = 0; pop_valid = 0; pop_vc = 0;
  - overflow = 0; now = 0; delay register = DEFAULT_DELAY.
- now increments by 1 every clk edge and wraps from 2^TIME_W-1 to 0.
- Push on port p is sampled at the edge where now == t:
  - entry stores {stamp = (t + delay) mod 2^TIME_W, vc};
  - tail pointer advances and wraps from DEPTH-1 to 0.
- Maturity: head is matured when (now - stamp) mod 2^TIME_W < 2^(TIME_W-1). This keeps the compare correct across counter wrap.
- pop_valid[p] = !empty[p] && head matured. Decoded combinationally from registered state, so it is never high in the push cycle.
  - Release latency = max(delay, 1) cycles: delay 0 gives pop_valid in the cycle where now == t+1.
- pop_vc[p] shows the head entry's VC whenever the queue is non-empty. Don't-care otherwise (drive 0).
- Pop happens when pop_valid & pop_ready are both high at an edge: head advances with wrap. pop_valid/pop_vc hold stable while pop_ready is low.
- Strict FIFO order per port: a later entry with an earlier stamp (after a delay change) waits behind the head.
- Count update:
  - push accepted and no pop: +1;
  - pop and no push: -1;
  - both: unchanged.
- Full without simultaneous pop: the push is dropped, storage is unchanged, and overflow[p] is set.
- Full with simultaneous pop: the push is accepted; count stays DEPTH.
- overflow set and clear_ovf in the same cycle: set wins.
- cfg_we: the delay register updates at the edge and affects only pushes in later cycles. A push in the same cycle uses the old delay. Stamps already stored are unchanged.
- Ports are fully independent; there is no shared arbitration.

Test Plan:
- Defaults: at now=10, push port0 vc=5 with pop_ready=0 -> pop_valid[0] low at now 11..13, first high at now=14 with pop_vc=5. It holds until pop_ready=1 at now=17, then empty[0]=1 and count[0]=0.
- Port1: 8 pushes -> full[1]=1, count=8. A 9th push -> dropped, overflow[1]=1, count=8. Push with a simultaneous pop at full -> accepted, count=8, last vc appears 8 pops later. clear_ovf[1] -> overflow[1]=0.
- cfg_we with delay_cfg=0, then push port2 at now=t -> pop_valid[2]=1 at now=t+1. Push in the cfg_we cycle itself uses delay 4.
- Reset, run to now=65534, push port3 with delay 4 -> stamp=2. pop_valid[3] low at now=65535, 0, 1; high at now=2.
- Push port0 vc=1 with delay 10, set delay 1, push vc=2 -> vc=2 not released before vc=1. Order is 1 then 2, with vc=2 valid the cycle after vc=1 pops.
- Assert rst with 3 entries queued on every port and overflow set -> immediately all empty=1, pop_valid=0, overflow=0, now=0. After release the delay is 4 again.

Source files
------------

// File: rtl/credit_stage_bank.sv
// Bank of per-port timed credit FIFOs: each credit is stamped with now + delay
// and released in FIFO order once the free-running counter has reached its stamp.
module credit_stage_bank #(
    parameter int NUM_PORTS     = 4,
    parameter int DEPTH         = 8,
    parameter int VC_W          = 3,
    parameter int TIME_W        = 16,
    parameter int DEFAULT_DELAY = 4,
    localparam int CW           = $clog2(DEPTH + 1)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      cfg_we,
    input  logic [TIME_W-1:0]         delay_cfg,
    input  logic [NUM_PORTS-1:0]      push_valid,
    input  logic [NUM_PORTS*VC_W-1:0] push_vc,
    output logic [NUM_PORTS-1:0]      pop_valid,
    output logic [NUM_PORTS*VC_W-1:0] pop_vc,
    input  logic [NUM_PORTS-1:0]      pop_ready,
    output logic [NUM_PORTS-1:0]      full,
    output logic [NUM_PORTS-1:0]      empty,
    output logic [NUM_PORTS*CW-1:0]   count,
    output logic [NUM_PORTS-1:0]      overflow,
    input  logic [NUM_PORTS-1:0]      clear_ovf,
    output logic [TIME_W-1:0]         now
);

    localparam int PW = $clog2(DEPTH);

    logic [TIME_W-1:0] r_now;
    logic [TIME_W-1:0] r_delay;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_now   <= '0;
            r_delay <= TIME_W'(DEFAULT_DELAY);
        end else begin
            r_now <= r_now + TIME_W'(1);
            if (cfg_we) begin
                r_delay <= delay_cfg;
            end
        end
    end

    assign now = r_now;

    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
        logic [TIME_W-1:0] r_stamp [DEPTH];
        logic [VC_W-1:0]   r_vc    [DEPTH];
        logic [PW-1:0]     r_head;
        logic [PW-1:0]     r_tail;
        logic [CW-1:0]     r_count;
        logic              r_ovf;
        logic              w_full;
        logic              w_empty;
        logic              w_mature;
        logic              w_valid;
        logic              w_pop;
        logic              w_push;
        logic              w_drop;
        logic [TIME_W-1:0] w_age;

        assign w_full   = (r_count == CW'(DEPTH));
        assign w_empty  = (r_count == '0);
        // Age taken modulo 2^TIME_W; the top bit set means the stamp is still in the future.
        assign w_age    = r_now - r_stamp[r_head];
        assign w_mature = ~w_age[TIME_W-1];
        assign w_valid  = ~w_empty & w_mature;
        assign w_pop    = w_valid & pop_ready[p];
        assign w_push   = push_valid[p] & (~w_full | w_pop);
        assign w_drop   = push_valid[p] & w_full & ~w_pop;

        always_ff @(posedge clk) begin
            if (w_push) begin
                r_stamp[r_tail] <= r_now + r_delay;
                r_vc[r_tail]    <= push_vc[p*VC_W +: VC_W];
            end
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_head  <= '0;
                r_tail  <= '0;
                r_count <= '0;
                r_ovf   <= 1'b0;
            end else begin
                if (w_push) begin
                    r_tail <= (r_tail == PW'(DEPTH - 1)) ? '0 : r_tail + PW'(1);
                end
                if (w_pop) begin
                    r_head <= (r_head == PW'(DEPTH - 1)) ? '0 : r_head + PW'(1);
                end
                case ({w_push, w_pop})
                    2'b10:   r_count <= r_count + CW'(1);
                    2'b01:   r_count <= r_count - CW'(1);
                    default: r_count <= r_count;
                endcase
                if (w_drop) begin
                    r_ovf <= 1'b1;
                end else if (clear_ovf[p]) begin
                    r_ovf <= 1'b0;
                end
            end
        end

        assign pop_valid[p]              = w_valid;
        assign pop_vc[p*VC_W +: VC_W]    = w_empty ? '0 : r_vc[r_head];
        assign full[p]                   = w_full;
        assign empty[p]                  = w_empty;
        assign count[p*CW +: CW]         = r_count;
        assign overflow[p]               = r_ovf;
    end

endmodule

// File: tb/tb_credit_stage_bank.sv
// Directed bench for credit_stage_bank: delay release, full/overflow, config timing,
// counter wrap, FIFO order under delay change and asynchronous reset.
module tb_credit_stage_bank;

    localparam int NP = 4;
    localparam int VW = 3;
    localparam int TW = 16;
    localparam int CW = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              cfg_we;
    logic [TW-1:0]     delay_cfg;
    logic [NP-1:0]     push_valid;
    logic [NP*VW-1:0]  push_vc;
    logic [NP-1:0]     pop_valid;
    logic [NP*VW-1:0]  pop_vc;
    logic [NP-1:0]     pop_ready;
    logic [NP-1:0]     full;
    logic [NP-1:0]     empty;
    logic [NP*CW-1:0]  count;
    logic [NP-1:0]     overflow;
    logic [NP-1:0]     clear_ovf;
    logic [TW-1:0]     now;

    int n_total = 0;
    int n_bad   = 0;

    credit_stage_bank dut (
        .clk        (clk),
        .rst        (rst),
        .cfg_we     (cfg_we),
        .delay_cfg  (delay_cfg),
        .push_valid (push_valid),
        .push_vc    (push_vc),
        .pop_valid  (pop_valid),
        .pop_vc     (pop_vc),
        .pop_ready  (pop_ready),
        .full       (full),
        .empty      (empty),
        .count      (count),
        .overflow   (overflow),
        .clear_ovf  (clear_ovf),
        .now        (now)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic run_to(input int t);
        int guard = 0;
        while (now != TW'(t) && guard < 70000) begin
            step();
            guard++;
        end
        chk("run_to", 32'(now), 32'(t));
    endtask

    function automatic logic [VW-1:0] vc_of(input int p);
        return pop_vc[p*VW +: VW];
    endfunction

    function automatic logic [CW-1:0] cnt_of(input int p);
        return count[p*CW +: CW];
    endfunction

    task automatic set_push(input int p, input int v);
        push_valid[p]      = 1'b1;
        push_vc[p*VW +: VW] = VW'(v);
    endtask

    int a;

    initial begin
        rst = 1'b1; cfg_we = 0; delay_cfg = '0; push_valid = '0; push_vc = '0;
        pop_ready = '0; clear_ovf = '0;
        repeat (2) step();
        chk("rst_empty", 32'(empty), 32'hF);
        chk("rst_full", 32'(full), 32'h0);
        chk("rst_pv", 32'(pop_valid), 32'h0);
        chk("rst_count", 32'(count), 32'h0);
        chk("rst_ovf", 32'(overflow), 32'h0);
        chk("rst_now", 32'(now), 32'h0);
        rst = 1'b0;

        // Default delay 4: push at now=10 matures at now=14
        run_to(10);
        set_push(0, 5);
        step(); push_valid = '0;
        for (int t = 11; t <= 13; t++) begin
            chk("t1_early", 32'(pop_valid[0]), 32'h0);
            step();
        end
        chk("t1_pv14", 32'(pop_valid[0]), 32'h1);
        chk("t1_vc14", 32'(vc_of(0)), 32'h5);
        chk("t1_cnt", 32'(cnt_of(0)), 32'h1);
        step(); step();
        chk("t1_hold16", 32'(pop_valid[0]), 32'h1);
        step();
        chk("t1_now17", 32'(now), 32'd17);
        pop_ready[0] = 1'b1;
        step(); pop_ready = '0;
        chk("t1_empty", 32'(empty[0]), 32'h1);
        chk("t1_cnt0", 32'(cnt_of(0)), 32'h0);

        // Port 1: fill, overflow, push-with-pop at full, drain order
        for (int i = 0; i < 8; i++) begin
            set_push(1, i);
            step();
        end
        push_valid = '0;
        chk("t2_full", 32'(full[1]), 32'h1);
        chk("t2_cnt8", 32'(cnt_of(1)), 32'h8);
        chk("t2_noovf", 32'(overflow[1]), 32'h0);
        set_push(1, 7);
        step(); push_valid = '0;
        chk("t2_ovf", 32'(overflow[1]), 32'h1);
        chk("t2_cnt_drop", 32'(cnt_of(1)), 32'h8);
        chk("t2_head0", 32'(vc_of(1)), 32'h0);
        chk("t2_pv", 32'(pop_valid[1]), 32'h1);
        set_push(1, 5); pop_ready[1] = 1'b1;
        step(); push_valid = '0; pop_ready = '0;
        chk("t2_cnt_pp", 32'(cnt_of(1)), 32'h8);
        chk("t2_ovf_kept", 32'(overflow[1]), 32'h1);
        clear_ovf[1] = 1'b1;
        step(); clear_ovf = '0;
        chk("t2_ovf_clr", 32'(overflow[1]), 32'h0);
        pop_ready[1] = 1'b1;
        for (int k = 1; k <= 7; k++) begin
            chk("t2_drain_vc", 32'(vc_of(1)), 32'(k));
            chk("t2_drain_pv", 32'(pop_valid[1]), 32'h1);
            step();
        end
        chk("t2_last_vc", 32'(vc_of(1)), 32'h5);
        chk("t2_last_pv", 32'(pop_valid[1]), 32'h1);
        step(); pop_ready = '0;
        chk("t2_empty", 32'(empty[1]), 32'h1);

        // cfg_we to delay 0: same-cycle push keeps delay 4, next push releases at t+1
        a = int'(now);
        cfg_we = 1'b1; delay_cfg = '0; set_push(0, 3);
        step(); cfg_we = 0; push_valid = '0;
        set_push(2, 4);
        step(); push_valid = '0;
        chk("t3_pv2", 32'(pop_valid[2]), 32'h1);
        chk("t3_vc2", 32'(vc_of(2)), 32'h4);
        chk("t3_old_a2", 32'(pop_valid[0]), 32'h0);
        step();
        chk("t3_old_a3", 32'(pop_valid[0]), 32'h0);
        step();
        chk("t3_now", 32'(now), 32'(a + 4));
        chk("t3_old_a4", 32'(pop_valid[0]), 32'h1);
        chk("t3_old_vc", 32'(vc_of(0)), 32'h3);
        pop_ready = 4'b0101;
        step(); pop_ready = '0;
        chk("t3_empty", 32'(empty), 32'hF);

        // FIFO order: vc1 with delay 10, then vc2 with delay 1 must wait behind it
        a = int'(now);
        cfg_we = 1'b1; delay_cfg = TW'(10);
        step();
        delay_cfg = TW'(1); set_push(0, 1);
        step(); cfg_we = 0; push_valid = '0;
        set_push(0, 2);
        step(); push_valid = '0;
        for (int t = a + 3; t < a + 11; t++) begin
            chk("t5_wait", 32'(pop_valid[0]), 32'h0);
            step();
        end
        chk("t5_first_pv", 32'(pop_valid[0]), 32'h1);
        chk("t5_first_vc", 32'(vc_of(0)), 32'h1);
        pop_ready[0] = 1'b1;
        step(); pop_ready = '0;
        chk("t5_second_pv", 32'(pop_valid[0]), 32'h1);
        chk("t5_second_vc", 32'(vc_of(0)), 32'h2);

        // Async reset mid-operation with queued entries and overflow
        push_valid = '1; push_vc = '0;
        repeat (3) step();
        push_valid = '0; push_valid[3] = 1'b1;
        repeat (6) step();
        push_valid = '0;
        chk("t6_pre_cnt", 32'(cnt_of(0)), 32'h4);
        chk("t6_pre_ovf", 32'(overflow[3]), 32'h1);
        rst = 1'b1;
        #1;
        chk("t6_empty", 32'(empty), 32'hF);
        chk("t6_pv", 32'(pop_valid), 32'h0);
        chk("t6_ovf", 32'(overflow), 32'h0);
        chk("t6_now", 32'(now), 32'h0);
        chk("t6_cnt", 32'(count), 32'h0);
        step(); step();
        rst = 1'b0;

        // Counter wrap with restored default delay: stamp 65534+4 wraps to 2
        run_to(65534);
        set_push(3, 6);
        step(); push_valid = '0;
        for (int t = 0; t < 3; t++) begin
            chk("t4_early", 32'(pop_valid[3]), 32'h0);
            step();
        end
        chk("t4_now2", 32'(now), 32'h2);
        chk("t4_pv", 32'(pop_valid[3]), 32'h1);
        chk("t4_vc", 32'(vc_of(3)), 32'h6);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
